// File: rtl/cmd_pkg.sv
// Shared command-path definitions: default widths and arbiter FSM/grant encodings.
package cmd_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    function automatic grant_t rr_pick(input logic pend_a, input logic pend_b, input grant_t last);
        if (pend_a && pend_b)
            return (last == GNT_A) ? GNT_B : GNT_A;
        else if (pend_a)
            return GNT_A;
        else
            return GNT_B;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Port-A command queue: DEPTH-entry synchronous FIFO with combinational head read.
module cmd_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    // A push into a full queue is still taken when the head leaves on the same edge.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Two-port command arbiter: queued strobe port A and handshake port B share one register-bus master.
module cmd_arbiter
    import cmd_pkg::*;
#(
    parameter int ADDR_W     = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_drop,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    input  logic              bus_ack,
    output logic              bus_err,
    output logic              busy
);

    localparam int CMD_W = ADDR_W + DATA_W;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t        r_state;
    arb_state_t        w_next;
    grant_t            r_gnt;
    grant_t            r_last;
    grant_t            w_pick;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_data;
    logic              r_a_drop;
    logic              r_bus_err;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CMD_W-1:0]  w_head;
    logic              w_pop;
    logic              w_timeout;

    // The queue head leaves only once its bus transaction has finished (ack or timeout).
    assign w_pop     = (r_state == ST_DONE) && (r_gnt == GNT_A);
    assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT));

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .rst     (rst),
        .i_push  (a_en),
        .i_data  ({a_addr, a_data}),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // State register.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and state-decoded outputs; b_valid is only looked at in IDLE.
    always_comb begin
        w_next  = r_state;
        w_pick  = rr_pick(!w_fifo_empty, b_valid, r_last);
        bus_req = 1'b0;
        busy    = 1'b1;
        b_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (!w_fifo_empty || b_valid)
                    w_next = ST_BUS;
            end
            ST_BUS: begin
                bus_req = 1'b1;
                if (bus_ack || w_timeout)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                b_ready = (r_gnt == GNT_B);
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant capture, payload latch, timeout counter and one-cycle status pulses.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_gnt      <= GNT_B;
            r_last     <= GNT_B;
            r_cnt      <= '0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_a_drop   <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_a_drop  <= a_en && w_fifo_full && !w_pop;
            r_bus_err <= (r_state == ST_BUS) && w_timeout && !bus_ack;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_BUS) begin
                        r_gnt <= w_pick;
                        r_cnt <= CNT_W'(1);
                        if (w_pick == GNT_A)
                            {r_bus_addr, r_bus_data} <= w_head;
                        else
                            {r_bus_addr, r_bus_data} <= {b_addr, b_data};
                    end
                end
                ST_BUS: begin
                    if (w_next == ST_BUS)
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    r_last <= r_gnt;
                    r_cnt  <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus_addr = r_bus_addr;
    assign bus_data = r_bus_data;
    assign a_drop   = r_a_drop;
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: cycle table for basic/round-robin flow, hand sequences for corners.
module tb_cmd_arbiter;

    localparam int AW = 8;
    localparam int DW = 17;

    logic          i_clk = 1'b0;
    logic          rst   = 1'b1;
    logic          a_en = 1'b0, b_valid = 1'b0, bus_ack = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_drop, b_ready, bus_req, bus_err, busy;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data;

    int n_chk = 0, n_err = 0;
    int n_drop = 0, n_berr = 0, n_brdy = 0;

    cmd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(5)) dut (
        .i_clk(i_clk), .rst(rst),
        .a_en(a_en), .a_addr(a_addr), .a_data(a_data), .a_drop(a_drop),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_ack(bus_ack), .bus_err(bus_err), .busy(busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          rst, a_en;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_data;
        logic          b_valid;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_data;
        logic          ack;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_brdy, e_busy, e_pl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic ae, logic [AW-1:0] aa, logic [DW-1:0] ad,
                               logic bv, logic [AW-1:0] ba, logic [DW-1:0] bd, logic ak,
                               logic er, logic [AW-1:0] ea, logic [DW-1:0] ed,
                               logic ebr, logic ebz, logic epl);
        vec_t t;
        t.rst = r; t.a_en = ae; t.a_addr = aa; t.a_data = ad;
        t.b_valid = bv; t.b_addr = ba; t.b_data = bd; t.ack = ak;
        t.e_req = er; t.e_addr = ea; t.e_data = ed;
        t.e_brdy = ebr; t.e_busy = ebz; t.e_pl = epl;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: inputs set at negedge, outputs observed at the following negedge.
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
        n_drop += int'(a_drop);
        n_berr += int'(bus_err);
        n_brdy += int'(b_ready);
    endtask

    task automatic do_reset();
        rst = 1'b1; a_en = 1'b0; b_valid = 1'b0; bus_ack = 1'b0;
        tick();
        rst = 1'b0;
        n_drop = 0; n_berr = 0; n_brdy = 0;
    endtask

    task automatic push_a(input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        a_en = 1'b1; a_addr = ad; a_data = dt;
        tick();
        a_en = 1'b0;
    endtask

    // Wait (bounded) for a bus request, check its payload, ack it once.
    task automatic serve(input string nm, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        int k = 0;
        while (!bus_req && k < 40) begin
            tick();
            k++;
        end
        chk({nm, " req"}, bus_req, 1);
        chk({nm, " addr"}, bus_addr, ea);
        chk({nm, " data"}, bus_data, ed);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk({nm, " req drop"}, bus_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Single A write acked after 3 bus cycles, then round-robin A/B after a fresh reset.
        vecs.push_back(v(1,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,1));
        vecs.push_back(v(0,1,8'h12,17'h0ABCD, 0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 1,8'h12,17'h0ABCD, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 1,8'h12,17'h0ABCD, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 1,8'h12,17'h0ABCD, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     1, 0,8'h00,17'h0,     0,1,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(1,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,1));
        vecs.push_back(v(0,1,8'h21,17'h00111, 0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(0,1,8'h22,17'h00222, 1,8'h40,17'h1B0B0, 0, 1,8'h21,17'h00111, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h40,17'h1B0B0, 1, 0,8'h00,17'h0,     0,1,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h40,17'h1B0B0, 0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h40,17'h1B0B0, 0, 1,8'h40,17'h1B0B0, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h40,17'h1B0B0, 1, 0,8'h00,17'h0,     1,1,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h41,17'h1C0C0, 0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h41,17'h1C0C0, 0, 1,8'h22,17'h00222, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h41,17'h1C0C0, 1, 0,8'h00,17'h0,     0,1,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h41,17'h1C0C0, 0, 0,8'h00,17'h0,     0,0,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h41,17'h1C0C0, 0, 1,8'h41,17'h1C0C0, 0,1,1));
        vecs.push_back(v(0,0,8'h00,17'h0,     1,8'h41,17'h1C0C0, 1, 0,8'h00,17'h0,     1,1,0));
        vecs.push_back(v(0,0,8'h00,17'h0,     0,8'h00,17'h0,     0, 0,8'h00,17'h0,     0,0,0));

        @(negedge i_clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; a_en = vecs[i].a_en; a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
            b_valid = vecs[i].b_valid; b_addr = vecs[i].b_addr; b_data = vecs[i].b_data;
            bus_ack = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d bus_req", i), bus_req, vecs[i].e_req);
            chk($sformatf("vec%0d b_ready", i), b_ready, vecs[i].e_brdy);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d a_drop", i), a_drop, 0);
            chk($sformatf("vec%0d bus_err", i), bus_err, 0);
            if (vecs[i].e_pl) begin
                chk($sformatf("vec%0d bus_addr", i), bus_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d bus_data", i), bus_data, vecs[i].e_data);
            end
        end
        rst = 1'b0; b_valid = 1'b0; bus_ack = 1'b0; a_en = 1'b0;

        // Six strobes into a depth-4 queue while the bus is stalled.
        do_reset();
        for (int i = 0; i < 6; i++)
            push_a(AW'(8'h30 + i), DW'(17'h100 + i));
        for (int i = 0; i < 4; i++)
            serve($sformatf("ovf%0d", i), AW'(8'h30 + i), DW'(17'h100 + i));
        tick(); tick();
        chk("ovf drops", n_drop, 2);
        chk("ovf errs", n_berr, 0);
        chk("ovf idle", busy, 0);

        // Full queue plus push on the pop edge: accepted, no drop, pointers wrap.
        do_reset();
        for (int i = 0; i < 4; i++)
            push_a(AW'(8'h70 + i), DW'(17'h0700 + i));
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("fullpop done", busy, 1);
        push_a(8'h7F, 17'h1FFFF);
        chk("fullpop drop", n_drop, 0);
        serve("fp1", 8'h71, 17'h00701);
        serve("fp2", 8'h72, 17'h00702);
        serve("fp3", 8'h73, 17'h00703);
        serve("fp4", 8'h7F, 17'h1FFFF);
        tick(); tick();
        chk("fullpop idle", busy, 0);

        // Timeout: no ack for 5 bus cycles.
        do_reset();
        push_a(8'h50, 17'h05050);
        push_a(8'h51, 17'h05151);
        n = 0;
        while (bus_req && n < 20) begin
            n++;
            tick();
        end
        chk("to req cycles", n, 5);
        chk("to bus_err", bus_err, 1);
        chk("to busy", busy, 1);
        tick();
        chk("to err pulse", bus_err, 0);
        serve("to next", 8'h51, 17'h05151);
        tick();
        chk("to idle", busy, 0);
        chk("to err count", n_berr, 1);

        // Ack on the very cycle the counter hits TIMEOUT.
        do_reset();
        push_a(8'h58, 17'h00058);
        tick();
        chk("edge req", bus_req, 1);
        repeat (4) tick();
        chk("edge still req", bus_req, 1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("edge no err", bus_err, 0);
        chk("edge done", busy, 1);
        tick();
        chk("edge idle", busy, 0);
        chk("edge err count", n_berr, 0);

        // Reset in the middle of a B transaction.
        do_reset();
        b_valid = 1'b1; b_addr = 8'h60; b_data = 17'h0F0F0;
        tick();
        chk("rstb req", bus_req, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rstb req0", bus_req, 0);
        chk("rstb busy0", busy, 0);
        chk("rstb addr0", bus_addr, 0);
        chk("rstb data0", bus_data, 0);
        chk("rstb rdy0", b_ready, 0);
        tick();
        rst = 1'b0;
        chk("rstb no rdy", n_brdy, 0);
        serve("rstb again", 8'h60, 17'h0F0F0);
        chk("rstb ready", b_ready, 1);
        b_valid = 1'b0;
        tick();
        chk("rstb rdy once", n_brdy, 1);
        chk("rstb err", n_berr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, command address width.
REQ-002 Parameter DATA_W, default 17, command data width (matches the UART command path).
REQ-003 Parameter FIFO_DEPTH, default 4, port-A queue depth; SHALL be a power of 2, at least 2.
REQ-004 Parameter TIMEOUT, default 255, bus cycles to wait for ack; 0 disables the timeout.
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 a_en  in  1  port A single-cycle command strobe; no backpressure.
REQ-008 a_addr / a_data  in  ADDR_W / DATA_W  port A command; sampled when a_en=1.
REQ-009 a_drop  out  1  one-cycle pulse: port A command lost because the queue was full.
REQ-010 b_valid  in  1  port B request; addr/data held stable until accepted.
REQ-011 b_addr / b_data  in  ADDR_W / DATA_W  port B command.
REQ-012 b_ready  out  1  one-cycle pulse: port B request consumed.
REQ-013 bus_req  out  1  register-bus write request.
REQ-014 bus_addr / bus_data  out  ADDR_W / DATA_W  register-bus write payload.
REQ-015 bus_ack  in  1  target acknowledge, sampled only while bus_req=1.
REQ-016 bus_err  out  1  one-cycle pulse: transaction abandoned on timeout.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 Port A SHALL push {a_addr,a_data} into a FIFO_DEPTH-entry synchronous FIFO on every a_en=1 cycle with FIFO not full.
REQ-019 a_en=1 with FIFO full and no pop in the same cycle SHALL drop the command and pulse a_drop the next cycle.
REQ-020 a_en=1 with FIFO full and a pop in the same cycle SHALL be accepted; occupancy unchanged, no a_drop.
REQ-021 FSM states: IDLE, BUS, DONE.
REQ-022 In IDLE, a requester is pending if FIFO is non-empty (A) or b_valid=1 (B); with none pending, stay in IDLE.
REQ-023 Arbitration SHALL be round-robin: with only one requester pending it is granted; with both pending, the one not granted last wins.
REQ-024 On grant, IDLE->BUS; the next cycle bus_req=1, with bus_addr/bus_data holding the FIFO head (A) or b_addr/b_data (B), registered at the grant edge.
REQ-025 bus_addr/bus_data SHALL remain stable for the whole BUS state.
REQ-026 In BUS, a timeout counter SHALL count cycles from 1; bus_ack=1 SHALL move BUS->DONE and deassert bus_req at the same edge.
REQ-027 TIMEOUT>0 and counter==TIMEOUT with bus_ack=0 SHALL move BUS->DONE and pulse bus_err during DONE; bus_ack in that same cycle takes priority (no bus_err).
REQ-028 DONE lasts exactly one cycle with bus_req=0. Grant A pops the FIFO head at the DONE edge; grant B asserts b_ready during DONE. Both happen on ack or timeout.
REQ-029 DONE->IDLE always; last-grant register updated at the DONE edge; minimum one idle cycle between bus_req pulses.
REQ-030 Port B sampling SHALL ignore b_valid during DONE, so a request is never consumed twice.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-032 rst=1 SHALL asynchronously force state IDLE, FIFO empty, counter 0, last-grant=B (A wins the first tie), and all outputs 0.
REQ-033 Reset mid-BUS SHALL abandon the transaction: no ack wait, no bus_err, no b_ready; port B re-presents afterward.

Structure
REQ-034 Shared package cmd_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state encoding, shared with the command receiver.
REQ-035 The FIFO SHALL be a sub-module cmd_fifo (push, pop, full, empty, head data), with arbitration/FSM in cmd_arbiter.

Verification
REQ-036 a_en with addr 0x12 and data 0x0ABCD, no B traffic, ack after 3 cycles -> bus_req for 3 cycles with addr 0x12 / data 0x0ABCD, FIFO empty, busy low after DONE.
REQ-037 A and B pending together after reset -> grant order A, B, A, B; b_ready pulses once per B grant.
REQ-038 Six back-to-back a_en (DEPTH 4) with bus stalled -> first 4 queued, a_drop pulses twice, then 4 bus writes in push order.
REQ-039 TIMEOUT=5, ack never asserted -> bus_req high 5 cycles, then bus_err one cycle, FIFO popped, next request served.
REQ-040 Ack on the cycle the counter reaches TIMEOUT -> no bus_err, normal completion.
REQ-041 rst pulse mid-BUS with B granted -> outputs 0 immediately, b_ready never pulses, B re-served after reset.
